// File: rtl/sr_mem_ctrl.sv
// Per-core memory controller: posted-write store buffer plus blocking loads
// on a shared word-addressed RAM port with req/gnt handshake.
module sr_mem_ctrl #(
  parameter int         ADDR_W    = 10,
  parameter int         SB_DEPTH  = 4,
  parameter logic [2:0] AGU_LOAD  = 3'd1,
  parameter logic [2:0] AGU_STORE = 3'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        aguInstruction,
  input  logic [31:0]       ramAddress,
  input  logic [31:0]       dataFromCpu,
  output logic [31:0]       dataToCpu,
  output logic              dataReceived,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              sb_empty,
  output logic              sb_overflow
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam logic [PW:0] ONE = (PW+1)'(1);
  localparam logic [PW:0] FULL = (PW+1)'(SB_DEPTH);

  typedef enum logic [2:0] {
    IDLE, DRAIN, LREQ, LWAIT, RESP
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] sbAddr [SB_DEPTH];
  logic [31:0]       sbData [SB_DEPTH];
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] loadAddr;
  logic [ADDR_W-1:0] wordAddr;
  logic              sbFull;
  logic              wrPhase;
  logic              isStore;
  logic              push;
  logic              pop;
  logic              goRead;
  logic              unusedAddrBits;

  assign wordAddr = ramAddress[ADDR_W+1:2];
  assign unusedAddrBits =
    ^{ramAddress[31:ADDR_W+2], ramAddress[1:0]};

  assign sb_empty = (count == '0);
  assign sbFull   = (count == FULL);
  assign wrPhase  = (state == IDLE || state == DRAIN) && !sb_empty;
  assign pop      = wrPhase && mem_gnt;
  assign isStore  = (state == IDLE) && (aguInstruction == AGU_STORE);
  assign push     = isStore && (!sbFull || pop);
  // Last buffered write leaving this cycle also clears the way for the read.
  assign goRead   = sb_empty || (pop && count == ONE);

  assign mem_req = wrPhase || (state == LREQ);
  assign mem_we  = wrPhase;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      wrPhase: begin
        mem_addr  = sbAddr[rdPtr];
        mem_wdata = sbData[rdPtr];
      end
      (state == LREQ): mem_addr = loadAddr;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sbAddr[wrPtr] <= wordAddr;
      sbData[wrPtr] <= dataFromCpu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wrPtr        <= '0;
      rdPtr        <= '0;
      count        <= '0;
      loadAddr     <= '0;
      dataToCpu    <= '0;
      dataReceived <= 1'b0;
      sb_overflow  <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (isStore && sbFull && !pop) sb_overflow <= 1'b1;
      dataReceived <= 1'b0;
      unique case (state)
        IDLE: begin
          if (aguInstruction == AGU_LOAD) begin
            loadAddr <= wordAddr;
            state    <= goRead ? LREQ : DRAIN;
          end
        end
        DRAIN: if (goRead) state <= LREQ;
        LREQ: if (mem_gnt) state <= LWAIT;
        LWAIT: begin
          if (mem_rvalid) begin
            dataToCpu    <= mem_rdata;
            dataReceived <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_mem_ctrl.sv
// Scoreboard bench for sr_mem_ctrl: directed stores/loads, RAM responder,
// decoupled monitor comparing writes, reads and load returns.
module tb_sr_mem_ctrl;

  localparam logic [2:0] LD = 3'd1;
  localparam logic [2:0] ST = 3'd2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  agu = 3'd0;
  logic [31:0] ramAddress = '0;
  logic [31:0] dataFromCpu = '0;
  logic [31:0] dataToCpu;
  logic        dataReceived;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        sb_empty;
  logic        sb_overflow;

  wr_t         expWr [$];
  logic [31:0] expRd [$];
  logic [31:0] expLd [$];
  logic [31:0] ram [int];
  wr_t         monW;
  int          rvDelay = 1;
  int          nChk = 0;
  int          nFail = 0;

  sr_mem_ctrl #(.ADDR_W(10), .SB_DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .aguInstruction(agu),
    .ramAddress(ramAddress),
    .dataFromCpu(dataFromCpu),
    .dataToCpu(dataToCpu),
    .dataReceived(dataReceived),
    .mem_req(mem_req),
    .mem_gnt(mem_gnt),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .sb_empty(sb_empty),
    .sb_overflow(sb_overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] ramRd(input int a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [31:0] d, input int dly);
    repeat (dly) @(posedge clk);
    #1;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] word, input bit keep);
    agu = ST;
    ramAddress = a;
    dataFromCpu = d;
    if (keep) expWr.push_back('{word, d});
    tick();
    agu = 3'd0;
  endtask

  task automatic waitResp(input int maxc);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (dataReceived) break;
      n++;
      if (n >= maxc) begin
        chk("respTimeout", 1, 0);
        break;
      end
    end
    tick();
  endtask

  task automatic checkIdle(input string tag);
    chk({tag, ".req"}, 32'(mem_req), 0);
    chk({tag, ".we"}, 32'(mem_we), 0);
    chk({tag, ".addr"}, 32'(mem_addr), 0);
    chk({tag, ".wdata"}, mem_wdata, 0);
    chk({tag, ".data"}, dataToCpu, 0);
    chk({tag, ".drcv"}, 32'(dataReceived), 0);
    chk({tag, ".empty"}, 32'(sb_empty), 1);
    chk({tag, ".ovf"}, 32'(sb_overflow), 0);
  endtask

  // Monitor: every granted access and every load return is scored here.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_req && mem_gnt && mem_we) begin
          if (expWr.size() == 0) chk("spuriousWrite", 1, 0);
          else begin
            monW = expWr.pop_front();
            chk("wrAddr", 32'(mem_addr), monW.a);
            chk("wrData", mem_wdata, monW.d);
          end
          ram[int'(mem_addr)] = mem_wdata;
        end
        if (mem_req && mem_gnt && !mem_we) begin
          chk("rdAfterWrites", 32'(expWr.size()), 0);
          if (expRd.size() == 0) chk("spuriousRead", 1, 0);
          else chk("rdAddr", 32'(mem_addr), expRd.pop_front());
          fork
            respond(ramRd(int'(mem_addr)), rvDelay);
          join_none
        end
        if (dataReceived) begin
          if (expLd.size() == 0) chk("spuriousResp", 1, 0);
          else chk("loadData", dataToCpu, expLd.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ram[32'h10] = 32'hDEADBEEF;
    ram[32'h30] = 32'h12345678;

    // Power-on reset
    repeat (3) @(negedge clk);
    checkIdle("por");
    rst_n = 1'b1;
    tick();

    // Load with exact latency: N, gnt N+1, rvalid N+2, resp N+3
    agu = LD;
    ramAddress = 32'h40;
    expRd.push_back(32'h10);
    expLd.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("ld.N.req", 32'(mem_req), 0);
    chk("ld.N.drcv", 32'(dataReceived), 0);
    tick();
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("ld.N1.req", 32'(mem_req), 1);
    chk("ld.N1.we", 32'(mem_we), 0);
    chk("ld.N1.addr", 32'(mem_addr), 32'h10);
    chk("ld.N1.drcv", 32'(dataReceived), 0);
    tick();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("ld.N2.drcv", 32'(dataReceived), 0);
    tick();
    @(negedge clk);
    chk("ld.N3.drcv", 32'(dataReceived), 1);
    chk("ld.N3.data", dataToCpu, 32'hDEADBEEF);
    tick();
    agu = 3'd0;
    @(negedge clk);
    chk("ld.N4.drcv", 32'(dataReceived), 0);
    repeat (2) tick();
    @(negedge clk);
    chk("ld.hold", dataToCpu, 32'hDEADBEEF);
    tick();

    // Three posted stores, grant withheld, then drained in order
    store(32'h0, 32'h11, 32'h0, 1'b1);
    store(32'h4, 32'h22, 32'h1, 1'b1);
    store(32'h8, 32'h33, 32'h2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("st.stableAddr", 32'(mem_addr), 32'h0);
      chk("st.stableData", mem_wdata, 32'h11);
      chk("st.notEmpty", 32'(sb_empty), 0);
      tick();
    end
    mem_gnt = 1'b1;
    repeat (3) tick();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("st.empty", 32'(sb_empty), 1);
    chk("st.idleReq", 32'(mem_req), 0);
    tick();

    // Store then load same word: write must land before the read
    store(32'h40, 32'hA5, 32'h10, 1'b1);
    agu = LD;
    ramAddress = 32'h40;
    expRd.push_back(32'h10);
    expLd.push_back(32'hA5);
    repeat (3) tick();
    mem_gnt = 1'b1;
    waitResp(20);
    agu = 3'd0;
    mem_gnt = 1'b0;
    repeat (3) tick();

    // Full buffer with a pop in the same cycle accepts the store
    for (int i = 0; i < 4; i++)
      store(32'h100 + 32'(i) * 4, 32'hB0 + 32'(i), 32'h40 + 32'(i), 1'b1);
    @(negedge clk);
    chk("full.notEmpty", 32'(sb_empty), 0);
    tick();
    mem_gnt = 1'b1;
    store(32'h110, 32'hB4, 32'h44, 1'b1);
    repeat (5) tick();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("full.noOvf", 32'(sb_overflow), 0);
    chk("full.empty", 32'(sb_empty), 1);
    tick();

    // Five stores with no grant: fifth dropped, overflow sticky
    for (int i = 0; i < 5; i++)
      store(32'h200 + 32'(i) * 4, 32'hC0 + 32'(i), 32'h80 + 32'(i), i < 4);
    @(negedge clk);
    chk("ovf.set", 32'(sb_overflow), 1);
    tick();
    mem_gnt = 1'b1;
    repeat (4) tick();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("ovf.sticky", 32'(sb_overflow), 1);
    chk("ovf.empty", 32'(sb_empty), 1);
    tick();

    // Asynchronous reset mid-run with stores pending
    store(32'h300, 32'hD0, 32'hC0, 1'b1);
    store(32'h304, 32'hD1, 32'hC1, 1'b1);
    @(negedge clk);
    chk("arst.preReq", 32'(mem_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("arst");
    expWr.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset during LWAIT; late rvalid after release must be ignored
    rvDelay = 4;
    agu = LD;
    ramAddress = 32'h80;
    expRd.push_back(32'h20);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    agu = 3'd0;
    #1;
    checkIdle("lwRst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lwRst.noResp", 32'(dataReceived), 0);
    end
    chk("lwRst.data", dataToCpu, 0);
    tick();

    // Next load after the aborted one behaves normally
    rvDelay = 1;
    agu = LD;
    ramAddress = 32'hC0;
    expRd.push_back(32'h30);
    expLd.push_back(32'h12345678);
    mem_gnt = 1'b1;
    waitResp(20);
    agu = 3'd0;
    mem_gnt = 1'b0;
    repeat (3) tick();

    chk("leftWrites", 32'(expWr.size()), 0);
    chk("leftReads", 32'(expRd.size()), 0);
    chk("leftLoads", 32'(expLd.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nChk, nFail);
    $finish;
  end

endmodule
